drm_17x256_fifo_ctrl: RTL and testbench



---
 rtl/drm_fifo_pkg.sv | 10 +
 rtl/drm_17x256.sv | 38 +++
 rtl/drm_17x256_fifo_ctrl.sv | 141 ++++++++++++++
 tb/tb_drm_17x256_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/drm_fifo_pkg.sv
// Shared constants for the DRM-backed FIFO controller.
package drm_fifo_pkg;

    localparam int unsigned DRM_DATA_WIDTH = 17;
    localparam int unsigned DRM_ADDR_WIDTH = 8;
    localparam int unsigned DEPTH          = 2 ** DRM_ADDR_WIDTH;
    localparam int unsigned OUT_STAGES     = 2;
    localparam int unsigned MAX_LEVEL      = DEPTH + OUT_STAGES;

endpackage

// File: rtl/drm_17x256.sv
// Behavioural model of the 17x256 simple dual-port DRM with a registered read port.
module drm_17x256 #(
    parameter int unsigned DATA_WIDTH = 17,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  wr_clk,
    input  logic                  wr_rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_clk,
    input  logic                  rd_rst,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    // Write port: one word per cycle, suppressed while in reset.
    always_ff @(posedge wr_clk) begin
        if (!wr_rst && wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port: data appears one cycle after rd_en, cleared by reset.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/drm_17x256_fifo_ctrl.sv
// First-word-fall-through valid/ready FIFO around the 17x256 DRM.
// A two-entry output stage (head + skid) hides the RAM read latency.
module drm_17x256_fifo_ctrl
    import drm_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DRM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = DRM_ADDR_WIDTH,
    parameter int unsigned AFULL_THRESH  = 240,
    parameter int unsigned AEMPTY_THRESH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam int unsigned CW        = ADDR_WIDTH + 1;
    localparam int unsigned RAM_DEPTH = 2 ** ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] wptr, wptr_n;
    logic [ADDR_WIDTH-1:0] rptr, rptr_n;
    logic [CW-1:0]         ram_cnt, ram_cnt_n;
    logic                  inflight, inflight_n;
    logic [1:0]            buf_cnt, buf_cnt_n;
    logic [DATA_WIDTH-1:0] skid, skid_n;
    logic [DATA_WIDTH-1:0] head_n;
    logic [CW-1:0]         level_n;
    logic                  s_ready_n, m_valid_n, afull_n, aempty_n;
    logic                  push, pop, issue;
    logic [2:0]            occ;
    logic [DATA_WIDTH-1:0] rd_data;

    drm_17x256 #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_drm (
        .wr_clk  (clk),
        .wr_rst  (~rst_n),
        .wr_en   (push),
        .wr_addr (wptr),
        .wr_data (s_data),
        .rd_clk  (clk),
        .rd_rst  (~rst_n),
        .rd_en   (issue),
        .rd_addr (rptr),
        .rd_data (rd_data)
    );

    // Next-state: handshakes, read issue, counts, output stage and flags.
    always_comb begin
        wptr_n     = wptr;
        rptr_n     = rptr;
        ram_cnt_n  = ram_cnt;
        skid_n     = skid;
        head_n     = m_data;
        push       = s_valid && s_ready;
        pop        = m_ready && m_valid;
        // Words already committed to the output stage after this cycle's pop.
        occ        = 3'(buf_cnt) + 3'(inflight) - 3'(pop);
        issue      = (ram_cnt != '0) && (occ < 3'(OUT_STAGES));
        inflight_n = issue;

        if (push) begin
            wptr_n = wptr + ADDR_WIDTH'(1);
        end
        if (issue) begin
            rptr_n = rptr + ADDR_WIDTH'(1);
        end

        case ({push, issue})
            2'b10:   ram_cnt_n = ram_cnt + CW'(1);
            2'b01:   ram_cnt_n = ram_cnt - CW'(1);
            default: ram_cnt_n = ram_cnt;
        endcase

        // Returning data goes to the head when it is free, else to the skid slot;
        // a pop with the skid slot full shifts the skid word forward first.
        if (pop) begin
            if (buf_cnt == 2'd2) begin
                head_n = skid;
                if (inflight) begin
                    skid_n = rd_data;
                end
            end else if (inflight) begin
                head_n = rd_data;
            end
        end else if (inflight) begin
            if (buf_cnt == 2'd0) begin
                head_n = rd_data;
            end else begin
                skid_n = rd_data;
            end
        end

        buf_cnt_n = buf_cnt + 2'(inflight) - 2'(pop);
        level_n   = ram_cnt_n + CW'(inflight_n) + CW'(buf_cnt_n);
        afull_n   = level_n >= CW'(AFULL_THRESH);
        aempty_n  = level_n <= CW'(AEMPTY_THRESH);
        s_ready_n = ram_cnt_n != CW'(RAM_DEPTH);
        m_valid_n = buf_cnt_n != 2'd0;
    end

    // State and registered outputs; reset discards all contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr         <= '0;
            rptr         <= '0;
            ram_cnt      <= '0;
            inflight     <= 1'b0;
            buf_cnt      <= '0;
            skid         <= '0;
            m_data       <= '0;
            level        <= '0;
            s_ready      <= 1'b0;
            m_valid      <= 1'b0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            wptr         <= wptr_n;
            rptr         <= rptr_n;
            ram_cnt      <= ram_cnt_n;
            inflight     <= inflight_n;
            buf_cnt      <= buf_cnt_n;
            skid         <= skid_n;
            m_data       <= head_n;
            level        <= level_n;
            s_ready      <= s_ready_n;
            m_valid      <= m_valid_n;
            almost_full  <= afull_n;
            almost_empty <= aempty_n;
        end
    end

endmodule

// File: tb/tb_drm_17x256_fifo_ctrl.sv
// Bench for drm_17x256_fifo_ctrl: directed scenarios plus random traffic
// checked against a queue-based model of the FIFO contents.
module tb_drm_17x256_fifo_ctrl;

    localparam int unsigned DW = 17;
    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [AW:0]   level;
    logic          almost_full;
    logic          almost_empty;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] q[$];
    int            qt[$];
    int            n        = 0;
    int            last_pop = -100;
    int            pushed   = 0;

    drm_17x256_fifo_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare every observable against the model's view of the contents.
    task automatic check_state();
        int lvl;
        lvl = q.size();
        check("level", 32'(level), 32'(lvl));
        check("almost_full", 32'(almost_full), 32'(lvl >= 240));
        check("almost_empty", 32'(almost_empty), 32'(lvl <= 16));
        if (lvl < 256) check("s_ready_open", 32'(s_ready), 32'd1);
        if (lvl == 258) check("s_ready_full", 32'(s_ready), 32'd0);
        if (m_valid) begin
            if (lvl == 0) check("m_valid_empty", 32'(m_valid), 32'd0);
            else          check("m_data_head", 32'(m_data), 32'(q[0]));
        end else if (lvl != 0 && qt[0] <= n - 2 && last_pop <= n - 2) begin
            check("m_valid_live", 32'(m_valid), 32'd1);
        end
    endtask

    // One clock: drive inputs, note handshakes, advance the model, check.
    task automatic cyc(input logic sv, input logic [DW-1:0] sd, input logic mr);
        logic          acc, pop, held;
        logic [DW-1:0] hd;
        s_valid = sv;
        s_data  = sd;
        m_ready = mr;
        acc  = sv && s_ready;
        pop  = mr && m_valid;
        held = m_valid && !mr;
        hd   = m_data;
        @(posedge clk);
        #1;
        n++;
        if (pop && q.size() != 0) begin
            void'(q.pop_front());
            void'(qt.pop_front());
            last_pop = n;
        end
        if (acc) begin
            q.push_back(sd);
            qt.push_back(n);
            pushed++;
        end
        if (held) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(hd));
        end
        check_state();
    endtask

    task automatic do_reset(input logic sv, input logic mr);
        rst_n   = 1'b0;
        s_valid = sv;
        s_data  = 17'h1F0F0;
        m_ready = mr;
        @(posedge clk);
        #1;
        n++;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        q.delete();
        qt.delete();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_aempty", 32'(almost_empty), 32'd1);
        @(posedge clk);
        #1;
        n++;
        check("rst_s_ready_rise", 32'(s_ready), 32'd1);
        check("rst_m_valid_after", 32'(m_valid), 32'd0);
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while (q.size() != 0 && g < 2000) begin
            cyc(1'b0, '0, 1'b1);
            g++;
        end
        check({tag, "_drained"}, 32'(q.size()), 32'd0);
        cyc(1'b0, '0, 1'b1);
        cyc(1'b0, '0, 1'b0);
        check({tag, "_idle_valid"}, 32'(m_valid), 32'd0);
        check({tag, "_idle_level"}, 32'(level), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int g;
        int expv;
        int first;
        int lvl_ref;

        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = '0;
        repeat (2) @(posedge clk);
        do_reset(1'b0, 1'b0);

        // Single word latency: visible two edges after the push.
        cyc(1'b1, 17'h1ABCD, 1'b0);
        check("lat_t0_valid", 32'(m_valid), 32'd0);
        cyc(1'b0, '0, 1'b0);
        check("lat_t1_valid", 32'(m_valid), 32'd0);
        check("lat_t1_level", 32'(level), 32'd1);
        cyc(1'b0, '0, 1'b0);
        check("lat_t2_valid", 32'(m_valid), 32'd1);
        check("lat_t2_data", 32'(m_data), 32'h1ABCD);
        cyc(1'b0, '0, 1'b1);
        check("lat_pop_level", 32'(level), 32'd0);
        check("lat_pop_aempty", 32'(almost_empty), 32'd1);

        // Fill to capacity with the consumer stalled.
        sent = 0;
        g    = 0;
        while (sent < 258 && g < 600) begin
            cyc(1'b1, DW'(sent), 1'b0);
            sent = q.size();
            g++;
        end
        repeat (3) cyc(1'b1, 17'h1FFFF, 1'b0);
        check("full_level", 32'(level), 32'd258);
        check("full_s_ready", 32'(s_ready), 32'd0);
        check("full_afull", 32'(almost_full), 32'd1);

        // One pop reopens the input one cycle later, then drain in order.
        cyc(1'b0, '0, 1'b1);
        check("reopen_s_ready", 32'(s_ready), 32'd1);
        expv = 1;
        g    = 0;
        while (q.size() != 0 && g < 1000) begin
            if (m_valid) begin
                check("drain_order", 32'(m_data), 32'(expv));
                expv++;
            end
            cyc(1'b0, '0, 1'b1);
            g++;
        end
        drain("full");

        // Streaming at full rate: no bubbles, constant level.
        first   = 0;
        lvl_ref = 0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1'b1, DW'(i + 1000), 1'b1);
            if (first != 0) begin
                check("stream_no_bubble", 32'(m_valid), 32'd1);
                check("stream_level", 32'(level), 32'(lvl_ref));
            end else if (m_valid) begin
                first   = 1;
                lvl_ref = q.size();
            end
        end
        drain("stream");

        // Random traffic with 30% push / 70% pop duty.
        sent = pushed;
        g    = 0;
        while (pushed - sent < 5000 && g < 40000) begin
            cyc(1'($urandom_range(0, 99) < 30), DW'($urandom), 1'($urandom_range(0, 99) < 70));
            g++;
        end
        check("rand_pushed", 32'(pushed - sent), 32'd5000);
        drain("rand");

        // Reset with 100 words held and a read in flight.
        g = 0;
        while (q.size() < 100 && g < 300) begin
            cyc(1'b1, DW'($urandom), 1'b0);
            g++;
        end
        repeat (3) cyc(1'b0, '0, 1'b0);
        cyc(1'b1, 17'h0AAAA, 1'b1);
        check("pre_rst_level", 32'(level), 32'd100);
        do_reset(1'b1, 1'b1);
        cyc(1'b1, 17'h00055, 1'b0);
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0);
        check("post_rst_valid", 32'(m_valid), 32'd1);
        check("post_rst_data", 32'(m_data), 32'h00055);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
